// File: rtl/sdc_cmd_sequencer.sv
// sdc_cmd_sequencer
//   Script engine that drives the sdc_controller register bus from a
//   programmable entry list. Entries are {op[2:0], addr[AW-1:0], data[DW-1:0]}:
//     000 WRITE  register write: SETUP (addr/data valid), STROBE (we=1), HOLD
//     001 WAIT   idle for data*WAIT_SCALE cycles
//     010 LOOP   while loop counter != 0: decrement and jump to data[PW-1:0]
//     011 END    terminate cleanly
//     100 POLL   wait until (reg_rdata & data) != 0 (only with SDC_SEQ_POLL_EN)
//     others     terminate with err=1
//   Every entry costs a FETCH (memory read issued) and a DECODE (entry valid)
//   cycle before its own states, so back-to-back WRITEs strobe 5 cycles apart.
//
//   Optional feature macro: SDC_SEQ_POLL_EN enables the POLL op. When it is
//   undefined, op 100 is illegal and reg_rdata is ignored.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, loop_cnt     run request (sampled in IDLE only) and loop count
//   prog_we/addr/data   script memory write port (ignored while busy)
//   reg_addr/wdata/we   register bus towards sdc_controller
//   reg_rdata           register read data from sdc_controller
//   busy, done, err     run status: busy while running, done one-cycle pulse,
//                       err sticky until the next accepted start
//   pc                  index of the entry in execution
module sdc_cmd_sequencer #(
  parameter int AW           = 7,
  parameter int DW           = 8,
  parameter int DEPTH        = 32,
  parameter int LCW          = 8,
  parameter int WAIT_SCALE   = 1,
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LCW-1:0]           loop_cnt,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [3+AW+DW-1:0]       prog_data,
  output logic [AW-1:0]            reg_addr,
  output logic [DW-1:0]            reg_wdata,
  output logic                     reg_we,
  input  logic [DW-1:0]            reg_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int PW  = $clog2(DEPTH);
  localparam int EW  = 3 + AW + DW;
  localparam int WCW = DW + $clog2(WAIT_SCALE + 1) + 1;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_WAIT  = 3'd1;
  localparam logic [2:0] OP_LOOP  = 3'd2;
  localparam logic [2:0] OP_END   = 3'd3;
  localparam logic [2:0] OP_POLL  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SETUP, S_STROBE,
    S_HOLD, S_WAIT, S_POLL, S_FINISH
  } state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  entry_q;
  logic [LCW-1:0] loop_q;
  logic [WCW-1:0] wait_cnt;
  logic [2:0]     e_op;
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_data;
  logic           last_entry;

  // Script memory: not reset. The read port follows pc every cycle; pc only
  // changes when entering FETCH and writes are blocked while busy, so entry_q
  // holds the current entry from DECODE onward.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
    entry_q <= mem[pc];
  end

  assign e_op       = entry_q[EW-1 -: 3];
  assign e_addr     = entry_q[DW +: AW];
  assign e_data     = entry_q[DW-1:0];
  assign last_entry = (pc == PW'(DEPTH - 1));

`ifdef SDC_SEQ_POLL_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0] poll_cnt;
`else
  logic unused_poll;
  assign unused_poll = (^reg_rdata) | (POLL_TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      loop_q    <= '0;
      wait_cnt  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef SDC_SEQ_POLL_EN
      poll_cnt  <= '0;
`endif
    end else begin
      done   <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= '0;
            loop_q <= loop_cnt;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (e_op)
            OP_WRITE: begin
              reg_addr  <= e_addr;
              reg_wdata <= e_data;
              state     <= S_SETUP;
            end
            OP_WAIT: begin
              if (e_data == '0) begin
                if (last_entry) begin
                  err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
                end else begin
                  pc <= pc + 1'b1; state <= S_FETCH;
                end
              end else begin
                wait_cnt <= WCW'(e_data) * WCW'(WAIT_SCALE) - WCW'(1);
                state    <= S_WAIT;
              end
            end
            OP_LOOP: begin
              if (loop_q != '0) begin
                loop_q <= loop_q - 1'b1;
                pc     <= e_data[PW-1:0];
                state  <= S_FETCH;
              end else if (last_entry) begin
                err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
              end else begin
                pc <= pc + 1'b1; state <= S_FETCH;
              end
            end
            OP_END: begin
              done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
            end
`ifdef SDC_SEQ_POLL_EN
            OP_POLL: begin
              reg_addr <= e_addr;
              poll_cnt <= '0;
              state    <= S_POLL;
            end
`endif
            default: begin
              err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
            end
          endcase
        end
        S_SETUP:  begin reg_we <= 1'b1; state <= S_STROBE; end
        S_STROBE: state <= S_HOLD;
        S_HOLD: begin
          if (last_entry) begin
            err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
          end else begin
            pc <= pc + 1'b1; state <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (last_entry) begin
            err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
          end else begin
            pc <= pc + 1'b1; state <= S_FETCH;
          end
        end
        S_POLL: begin
`ifdef SDC_SEQ_POLL_EN
          if ((reg_rdata & e_data) != '0) begin
            if (last_entry) begin
              err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
            end else begin
              pc <= pc + 1'b1; state <= S_FETCH;
            end
          end else if (poll_cnt == PCW'(POLL_TIMEOUT - 1)) begin
            err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
`else
          // Unreachable without the POLL feature; terminate defensively.
          err <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= S_FINISH;
`endif
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// tb_sdc_cmd_sequencer
//   Directed bench for sdc_cmd_sequencer (WAIT_SCALE=4, POLL_TIMEOUT=64).
//   Cycle numbers below count posedges after the edge that accepts start
//   (P0 = first FETCH). A WRITE entry strobes at FETCH+3, so the first
//   strobe is at P3 and consecutive WRITEs strobe 5 cycles apart.
module tb_sdc_cmd_sequencer;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int LCW = 8;
  localparam int PW = 5;
  localparam int PT = 64;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_WAIT  = 3'd1;
  localparam logic [2:0] OP_LOOP  = 3'd2;
  localparam logic [2:0] OP_END   = 3'd3;
  localparam logic [2:0] OP_POLL  = 3'd4;
  localparam logic [2:0] OP_BAD   = 3'd7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LCW-1:0]    loop_cnt = '0;
  logic              prog_we = 1'b0;
  logic [PW-1:0]     prog_addr = '0;
  logic [3+AW+DW-1:0] prog_data = '0;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic              reg_we;
  logic [DW-1:0]     reg_rdata = '0;
  logic              busy, done, err;
  logic [PW-1:0]     pc;

  sdc_cmd_sequencer #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .LCW(LCW),
    .WAIT_SCALE(4), .POLL_TIMEOUT(PT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .loop_cnt(loop_cnt),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy), .done(done), .err(err), .pc(pc)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // counters and scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    pa_q[$];
  logic [DW-1:0]    pd_q[$];
  int               pt_q[$];
  int  n_done = 0;
  logic prev_we = 1'b0;
  logic left0 = 1'b0;
  logic wrapped = 1'b0;
  int  t_acc, t_done;
  logic err_d, busy_d;
  logic [PW-1:0] pc_d;
  int  save_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // monitor, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (reg_we) begin
      check("we_single_cycle", {31'b0, prev_we}, 32'd0);
      pa_q.push_back(reg_addr);
      pd_q.push_back(reg_wdata);
      pt_q.push_back(cyc);
    end
    prev_we = reg_we;
    if (done) n_done++;
    if (busy && pc != '0) left0 = 1'b1;
    if (busy && pc == '0 && left0) wrapped = 1'b1;
  end

  // driver tasks
  task automatic prog(input int idx, input logic [2:0] op, input int a, input int d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = idx[PW-1:0];
    prog_data = {op, a[AW-1:0], d[DW-1:0]};
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic expect_we(input int a, input int d);
    exp_q.push_back({a[AW-1:0], d[DW-1:0]});
  endtask

  task automatic start_script(input logic [LCW-1:0] lc);
    @(negedge clk);
    pa_q.delete(); pd_q.delete(); pt_q.delete();
    left0 = 1'b0; wrapped = 1'b0;
    loop_cnt = lc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
    t_done = cyc; err_d = err; busy_d = busy; pc_d = pc;
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_we_count"}, pa_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pa_q.size(); i++)
      check($sformatf("%s_we_%0d", tag, i), {17'b0, pa_q[i], pd_q[i]}, {17'b0, exp_q[i]});
    exp_q.delete();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_reg_we", {31'b0, reg_we}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_pc", {27'b0, pc}, 0);
    check("rst_reg_addr", {25'b0, reg_addr}, 0);
    rst = 1'b0;

    // T1: two writes then END
    prog(0, OP_WRITE, 5, 0);
    prog(1, OP_WRITE, 0, 0);
    prog(2, OP_END, 0, 0);
    start_script(8'd0);
    check("t1_busy_after_start", {31'b0, busy}, 1);
    wait_done("t1", 200);
    expect_we(5, 0); expect_we(0, 0);
    check_pulses("t1");
    check("t1_first_latency", pt_q[0] - t_acc, 3);
    check("t1_we_gap", pt_q[1] - pt_q[0], 5);
    check("t1_done_time", t_done - t_acc, 12);
    check("t1_err", {31'b0, err_d}, 0);
    check("t1_busy_at_done", {31'b0, busy_d}, 0);
    check("t1_pc_at_done", {27'b0, pc_d}, 2);
    // start coincident with done must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_done_one_cycle", {31'b0, done}, 0);
    check("t1_start_at_done_ignored", {31'b0, busy}, 0);
    @(negedge clk);
    check("t1_still_idle", {31'b0, busy}, 0);
    check("t1_reg_addr_kept", {25'b0, reg_addr}, 0);

    // T2: WAIT 10 with WAIT_SCALE=4, plus a start while busy (ignored)
    prog(0, OP_WRITE, 5, 17);
    prog(1, OP_WAIT, 0, 10);
    prog(2, OP_WRITE, 0, 0);
    prog(3, OP_END, 0, 0);
    start_script(8'd0);
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2", 300);
    expect_we(5, 17); expect_we(0, 0);
    check_pulses("t2");
    check("t2_we_gap", pt_q[1] - pt_q[0], 47);
    check("t2_done_time", t_done - t_acc, 54);
    check("t2_err", {31'b0, err_d}, 0);

    // T4: 32 WRITEs without END -> error, no wrap
    for (int i = 0; i < DEPTH; i++) begin
      prog(i, OP_WRITE, i, i + 100);
      expect_we(i, i + 100);
    end
    start_script(8'd0);
    wait_done("t4", 400);
    check_pulses("t4");
    check("t4_done_time", t_done - t_acc, 160);
    check("t4_err", {31'b0, err_d}, 1);
    check("t4_pc_at_done", {27'b0, pc_d}, 31);
    check("t4_no_wrap", {31'b0, wrapped}, 0);

    // T3: loop 3 times (err from T4 must be cleared by start)
    prog(0, OP_WRITE, 3, 0);
    prog(1, OP_LOOP, 0, 0);
    prog(2, OP_END, 0, 0);
    start_script(8'd3);
    check("t3_err_cleared", {31'b0, err}, 0);
    wait_done("t3", 300);
    for (int i = 0; i < 4; i++) expect_we(3, 0);
    check("t3_we_gap", pt_q[1] - pt_q[0], 7);
    check("t3_we_gap_last", pt_q[3] - pt_q[2], 7);
    check_pulses("t3");
    check("t3_done_time", t_done - t_acc, 30);
    check("t3_err", {31'b0, err_d}, 0);

    // T7: illegal opcode after one write
    prog(0, OP_WRITE, 1, 1);
    prog(1, OP_BAD, 0, 0);
    start_script(8'd0);
    wait_done("t7", 100);
    expect_we(1, 1);
    check_pulses("t7");
    check("t7_done_time", t_done - t_acc, 7);
    check("t7_err", {31'b0, err_d}, 1);

    // T5: reset during STROBE, then restart from entry 0
    prog(0, OP_WRITE, 5, 0);
    prog(1, OP_WRITE, 0, 0);
    prog(2, OP_END, 0, 0);
    start_script(8'd0);
    for (int i = 0; i < 50 && !reg_we; i++) @(negedge clk);
    check("t5_in_strobe", {31'b0, reg_we}, 1);
    save_done = n_done;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_we", {31'b0, reg_we}, 0);
    check("t5_rst_busy", {31'b0, busy}, 0);
    check("t5_rst_done", {31'b0, done}, 0);
    check("t5_rst_err", {31'b0, err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_done_pulse", n_done, save_done);
    check("t5_still_idle", {31'b0, busy}, 0);
    start_script(8'd0);
    wait_done("t5", 200);
    expect_we(5, 0); expect_we(0, 0);
    check_pulses("t5");
    check("t5_done_time", t_done - t_acc, 12);
    check("t5_err", {31'b0, err_d}, 0);

    // T6: POLL
    prog(0, OP_POLL, 8, 1);
    prog(1, OP_END, 0, 0);
`ifdef SDC_SEQ_POLL_EN
    reg_rdata = '0;
    start_script(8'd0);
    repeat (20) @(negedge clk);
    check("t6_poll_addr", {25'b0, reg_addr}, 8);
    check("t6_poll_busy", {31'b0, busy}, 1);
    reg_rdata = 8'h01;
    wait_done("t6a", 100);
    reg_rdata = '0;
    check("t6a_done_time", t_done - t_acc, 23);
    check("t6a_err", {31'b0, err_d}, 0);
    check("t6a_no_we", pa_q.size(), 0);
    start_script(8'd0);
    wait_done("t6b", 300);
    check("t6b_done_time", t_done - t_acc, 2 + PT);
    check("t6b_err", {31'b0, err_d}, 1);
`else
    start_script(8'd0);
    wait_done("t6", 100);
    check("t6_done_time", t_done - t_acc, 2);
    check("t6_err", {31'b0, err_d}, 1);
    check("t6_no_we", pa_q.size(), 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
